// File: rtl/mem_wr_buffer.sv
// rtl/mem_wr_buffer.sv - posted-write buffer with youngest-match read forwarding
// Reads beat queued writes to memory; one memory transaction is in flight at a time.
module mem_wr_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         s_req_rd,
  input  logic [AW-1:0]                s_addr_rd,
  output logic                         s_rd_rdy,
  output logic                         s_rd_valid,
  output logic [DW-1:0]                s_data_rd,
  input  logic                         s_req_wr,
  input  logic [AW-1:0]                s_addr_wr,
  input  logic [DW-1:0]                s_data_wr,
  output logic                         s_wr_rdy,
  output logic                         m_req_rd,
  output logic                         m_req_wr,
  output logic [AW-1:0]                m_addr_rd,
  output logic [AW-1:0]                m_addr_wr,
  output logic [DW-1:0]                m_data_wr,
  input  logic [DW-1:0]                m_data_rd,
  input  logic                         m_data_rdy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_LO, ST_WAIT_HI} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_fifo_addr [DEPTH];
  logic [DW-1:0]   r_fifo_data [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            r_rd_pending;
  logic [AW-1:0]   r_rd_addr;
  logic            r_rd_valid;
  logic [DW-1:0]   r_data_rd;
  logic            r_req_rd;
  logic            r_req_wr;
  logic [AW-1:0]   r_addr_rd;
  logic [AW-1:0]   r_addr_wr;
  logic [DW-1:0]   r_data_wr;
  logic            r_xfer_rd;

  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_hit;
  logic [DW-1:0]   w_hit_data;
  logic [PW-1:0]   w_idx;
  logic            w_start_rd;
  logic            w_start_wr;
  logic            w_done;
  logic            w_pop;
  logic            w_rd_done;

  assign w_wr_acc = s_req_wr && (r_count < CW'(DEPTH));
  assign w_rd_acc = s_req_rd && !r_rd_pending;

  // Scan oldest to youngest so the last match wins; an entry pushed this edge is not yet visible.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_fifo_addr[w_idx] == s_addr_rd)) begin
        w_hit      = 1'b1;
        w_hit_data = r_fifo_data[w_idx];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_rd  = 1'b0;
    w_start_wr  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m_data_rdy && r_rd_pending) begin
          w_start_rd  = 1'b1;
          w_state_nxt = ST_REQ;
        end else if (m_data_rdy && (r_count != '0)) begin
          w_start_wr  = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ:     w_state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (!m_data_rdy) w_state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (m_data_rdy) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_pop     = w_done && !r_xfer_rd;
  assign w_rd_done = w_done && r_xfer_rd;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_fifo_addr[r_wr_ptr] <= s_addr_wr;
      r_fifo_data[r_wr_ptr] <= s_data_wr;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rd_pending <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_valid   <= 1'b0;
      r_data_rd    <= '0;
      r_req_rd     <= 1'b0;
      r_req_wr     <= 1'b0;
      r_addr_rd    <= '0;
      r_addr_wr    <= '0;
      r_data_wr    <= '0;
      r_xfer_rd    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_rd   <= w_start_rd;
      r_req_wr   <= w_start_wr;
      r_rd_valid <= 1'b0;

      if (w_start_rd) begin
        r_addr_rd <= r_rd_addr;
        r_xfer_rd <= 1'b1;
      end else if (w_start_wr) begin
        r_addr_wr <= r_fifo_addr[r_rd_ptr];
        r_data_wr <= r_fifo_data[r_rd_ptr];
        r_xfer_rd <= 1'b0;
      end

      if (w_rd_acc && w_hit) begin
        r_rd_valid <= 1'b1;
        r_data_rd  <= w_hit_data;
      end else if (w_rd_acc) begin
        r_rd_pending <= 1'b1;
        r_rd_addr    <= s_addr_rd;
      end else if (w_rd_done) begin
        r_rd_valid   <= 1'b1;
        r_data_rd    <= m_data_rd;
        r_rd_pending <= 1'b0;
      end

      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr_acc && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr_acc && w_pop) r_count <= r_count - CW'(1);
    end
  end

  assign s_rd_rdy   = !r_rd_pending;
  assign s_wr_rdy   = (r_count < CW'(DEPTH));
  assign s_rd_valid = r_rd_valid;
  assign s_data_rd  = r_data_rd;
  assign m_req_rd   = r_req_rd;
  assign m_req_wr   = r_req_wr;
  assign m_addr_rd  = r_addr_rd;
  assign m_addr_wr  = r_addr_wr;
  assign m_data_wr  = r_data_wr;
  assign count      = r_count;
  assign idle       = (r_count == '0) && !r_rd_pending && (r_state == ST_IDLE);

endmodule

// File: tb/tb_mem_wr_buffer.sv
// tb/tb_mem_wr_buffer.sv - scoreboard bench for mem_wr_buffer
// Reference: queue of posted writes plus a flat memory map; reads return the youngest queued match.
module tb_mem_wr_buffer;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        s_req_rd, s_req_wr;
  logic [31:0] s_addr_rd, s_addr_wr, s_data_wr;
  logic        s_rd_rdy, s_rd_valid, s_wr_rdy;
  logic [31:0] s_data_rd;
  logic        m_req_rd, m_req_wr;
  logic [31:0] m_addr_rd, m_addr_wr, m_data_wr, m_data_rd;
  logic        m_data_rdy;
  logic [2:0]  count;
  logic        idle;

  always #5 clk = ~clk;

  mem_wr_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_req_rd(s_req_rd), .s_addr_rd(s_addr_rd), .s_rd_rdy(s_rd_rdy),
    .s_rd_valid(s_rd_valid), .s_data_rd(s_data_rd),
    .s_req_wr(s_req_wr), .s_addr_wr(s_addr_wr), .s_data_wr(s_data_wr), .s_wr_rdy(s_wr_rdy),
    .m_req_rd(m_req_rd), .m_req_wr(m_req_wr), .m_addr_rd(m_addr_rd), .m_addr_wr(m_addr_wr),
    .m_data_wr(m_data_wr), .m_data_rd(m_data_rd), .m_data_rdy(m_data_rdy),
    .count(count), .idle(idle)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Two-cycle memory: ready drops on the sampling edge and returns two edges later.
  logic [31:0] mem [4096];
  logic        mem_rdy_r = 1'b1;
  int          mem_busy  = 0;
  logic        stall     = 1'b0;
  logic [31:0] mem_q     = '0;
  assign m_data_rdy = mem_rdy_r & ~stall;
  assign m_data_rd  = mem_q;

  always @(posedge clk) begin
    if (m_req_wr) mem[m_addr_wr[13:2]] <= m_data_wr;
    if (m_req_rd) mem_q <= mem[m_addr_rd[13:2]];
    if (m_req_rd || m_req_wr) begin
      mem_rdy_r <= 1'b0;
      mem_busy  <= 2;
    end else if (mem_busy > 0) begin
      mem_busy <= mem_busy - 1;
      if (mem_busy == 1) mem_rdy_r <= 1'b1;
    end
  end

  typedef struct packed { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ref_mem [logic [31:0]];
  byte         log_q[$];
  int          wr_seen = 0;
  int          rd_seen = 0;

  always @(posedge clk) begin
    ent_t        e;
    logic [31:0] v;
    if (!arst_n) begin
      mq.delete();
      exp_rd.delete();
    end else begin
      if (m_req_wr) begin
        wr_seen++;
        log_q.push_back("W");
        if (mq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wr_unexpected: got addr %0h with no queued write", m_addr_wr);
        end else begin
          e = mq.pop_front();
          check("m_addr_wr", m_addr_wr, e.a);
          check("m_data_wr", m_data_wr, e.d);
          ref_mem[e.a] = e.d;
        end
      end
      if (m_req_rd) begin
        rd_seen++;
        log_q.push_back("R");
      end
      if (s_req_rd && s_rd_rdy) begin
        v = ref_mem.exists(s_addr_rd) ? ref_mem[s_addr_rd] : 32'h0;
        foreach (mq[i]) if (mq[i].a == s_addr_rd) v = mq[i].d;
        exp_rd.push_back(v);
      end
      if (s_req_wr && s_wr_rdy) begin
        e.a = s_addr_wr;
        e.d = s_data_wr;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] x;
    if (arst_n && s_rd_valid) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: got %0h with no read outstanding", s_data_rd);
      end else begin
        x = exp_rd.pop_front();
        check("s_data_rd", s_data_rd, x);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (!idle && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, idle, 1);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    s_req_wr = 1'b1; s_addr_wr = a; s_data_wr = d;
    @(negedge clk);
    s_req_wr = 1'b0;
  endtask

  task automatic do_rd(input logic [31:0] a);
    @(negedge clk);
    s_req_rd = 1'b1; s_addr_rd = a;
    @(negedge clk);
    s_req_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rbase, cyc, n;
    logic saw;
    arst_n = 1'b0;
    s_req_rd = 0; s_req_wr = 0; s_addr_rd = 0; s_addr_wr = 0; s_data_wr = 0;
    @(negedge clk); @(negedge clk);
    check("rst_count", count, 0);
    check("rst_wr_rdy", s_wr_rdy, 1);
    check("rst_rd_rdy", s_rd_rdy, 1);
    check("rst_idle", idle, 1);
    check("rst_req_rd", m_req_rd, 0);
    check("rst_req_wr", m_req_wr, 0);
    check("rst_rd_valid", s_rd_valid, 0);
    check("rst_data_rd", s_data_rd, 0);
    arst_n = 1'b1;
    @(negedge clk);

    base = wr_seen;
    @(negedge clk);
    s_req_wr = 1'b1; s_addr_wr = 32'h4000_2004; s_data_wr = 32'hDEAD_BEEF;
    @(negedge clk);
    s_req_wr = 1'b0;
    check("t2_count1", count, 1);
    wait_idle("t2_idle");
    check("t2_count0", count, 0);
    check("t2_wr_pulses", wr_seen - base, 1);

    stall = 1'b1;
    base = wr_seen;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) check("t3_wr_rdy_full", s_wr_rdy, 0);
      s_req_wr = 1'b1; s_addr_wr = 32'h500 + 4 * i; s_data_wr = 32'h5000 + i;
    end
    @(negedge clk);
    s_req_wr = 1'b0;
    check("t3_count4", count, 4);
    stall = 1'b0;
    wait_idle("t3_idle");
    check("t3_wr_pulses", wr_seen - base, 4);

    stall = 1'b1;
    rbase = rd_seen;
    do_wr(32'h10, 32'h11);
    do_wr(32'h10, 32'h22);
    @(negedge clk);
    s_req_rd = 1'b1; s_addr_rd = 32'h10;
    @(negedge clk);
    s_req_rd = 1'b0;
    check("t4_hit_valid", s_rd_valid, 1);
    check("t4_hit_data", s_data_rd, 32'h22);
    stall = 1'b0;
    wait_idle("t4_idle");
    check("t4_no_mem_rd", rd_seen - rbase, 0);

    do_wr(32'h4000_0008, 32'h1234_5678);
    wait_idle("t5_pre_idle");
    rbase = rd_seen;
    @(negedge clk);
    s_req_rd = 1'b1; s_addr_rd = 32'h4000_0008;
    @(negedge clk);
    s_req_rd = 1'b0;
    cyc = 0;
    while (!s_rd_valid && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_latency", cyc, 5);
    check("t5_data", s_data_rd, 32'h1234_5678);
    wait_idle("t5_idle");
    check("t5_rd_pulses", rd_seen - rbase, 1);

    do_wr(32'h20, 32'h33);
    wait_idle("t6_pre_idle");
    log_q.delete();
    @(negedge clk);
    s_req_rd = 1'b1; s_addr_rd = 32'h20;
    s_req_wr = 1'b1; s_addr_wr = 32'h20; s_data_wr = 32'h55;
    @(negedge clk);
    s_req_rd = 1'b0; s_req_wr = 1'b0;
    wait_idle("t6_idle");
    @(negedge clk);
    check("t6_log_len", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t6_first_rd", log_q[0], "R");
      check("t6_then_wr", log_q[1], "W");
    end
    check("t6_data", s_data_rd, 32'h33);

    @(negedge clk);
    s_req_wr = 1'b1; s_addr_wr = 32'h300; s_data_wr = 32'h7;
    @(negedge clk);
    s_addr_wr = 32'h304; s_data_wr = 32'h8;
    @(negedge clk);
    s_req_wr = 1'b0;
    n = 0;
    while (!m_req_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t7_req_seen", m_req_wr, 1);
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    check("t7_req_wr", m_req_wr, 0);
    check("t7_req_rd", m_req_rd, 0);
    check("t7_addr_wr", m_addr_wr, 0);
    check("t7_data_wr", m_data_wr, 0);
    check("t7_addr_rd", m_addr_rd, 0);
    check("t7_data_rd", s_data_rd, 0);
    check("t7_count", count, 0);
    check("t7_idle", idle, 1);
    check("t7_wr_rdy", s_wr_rdy, 1);
    check("t7_rd_rdy", s_rd_rdy, 1);
    stall = 1'b1;
    @(negedge clk); @(negedge clk);
    arst_n = 1'b1;
    base = wr_seen;
    do_wr(32'h400, 32'hABCD);
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_req_wr) saw = 1'b1;
    end
    check("t7_wait_rdy", saw, 0);
    stall = 1'b0;
    wait_idle("t7_idle_after");
    check("t7_wr_after", wr_seen - base, 1);
    do_rd(32'h400);
    wait_idle("t7_rd_idle");
    check("t7_rd_new", s_data_rd, 32'hABCD);
    do_rd(32'h300);
    wait_idle("t7_rd_idle2");
    check("t7_rd_old", s_data_rd, 32'h7);

    for (int i = 0; i < 4; i++) do_wr(32'h1000 + 4 * i, $urandom);
    wait_idle("rnd_pre_idle");
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      s_req_wr  = ($urandom % 3) == 0;
      s_addr_wr = 32'h1000 + 4 * ($urandom % 4);
      s_data_wr = $urandom;
      s_req_rd  = ($urandom % 4) == 0;
      s_addr_rd = 32'h1000 + 4 * ($urandom % 4);
      if (($urandom % 10) == 0) stall = ~stall;
    end
    @(negedge clk);
    s_req_wr = 1'b0; s_req_rd = 1'b0; stall = 1'b0;
    wait_idle("rnd_idle");
    @(negedge clk); @(negedge clk);
    check("rnd_rd_drained", exp_rd.size(), 0);
    check("rnd_wr_drained", mq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
